// File: rtl/par2ser_pkg.sv
// Shared types and sizing helpers for the par2ser_tx transmit stage.
// PAR2SER_PARITY_EN: when defined, every frame carries one trailing even-parity bit.
package par2ser_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

`ifdef PAR2SER_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  // Divider must hold DIV-1 without wrapping.
  function automatic int div_w(input int div);
    return $clog2(div + 1);
  endfunction

  // Bit counter must hold WIDTH (the parity build starts one higher).
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  // Gap counter keeps at least one bit so GAP=0 still elaborates.
  function automatic int gap_w(input int gap);
    return (gap < 2) ? 1 : $clog2(gap + 1);
  endfunction

endpackage

// File: rtl/par2ser_if.sv
// Upstream word handshake into par2ser_tx.
// A word transfers on a clock edge where s_valid and s_ready are both high;
// s_data/msb_first are sampled only on that edge, s_ready never depends on
// s_valid, and s_valid may be dropped at any time.
interface par2ser_if #(
  parameter int WIDTH = 8
);
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             msb_first;

  modport master (output s_valid, output s_data, output msb_first, input s_ready);
  modport slave  (input s_valid, input s_data, input msb_first, output s_ready);
endinterface

// File: rtl/par2ser_tx_bit_tick_gen.sv
// Reloadable bit-period divider: tick is high in the last clock of every
// DIV-clock period; restart reloads so a new period begins on the next clock.
module bit_tick_gen
  import par2ser_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic aclr,
  input  logic restart,
  output logic tick
);

  localparam int DW = div_w(DIV);

  logic [DW-1:0] cnt;

  // Count down to zero, then reload; restart forces a fresh period.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      cnt <= '0;
    end else if (restart || (cnt == '0)) begin
      cnt <= DW'(DIV - 1);
    end else begin
      cnt <= cnt - DW'(1);
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/par2ser_tx.sv
// Parallel-to-serial transmitter: accepts a word, then drives it out one bit
// per DIV clocks with sframe/bit_stb framing, followed by GAP idle bit periods.
// PAR2SER_PARITY_EN: when defined, an even-parity bit follows the data bits.
module par2ser_tx
  import par2ser_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 4,
  parameter int GAP   = 1
) (
  input  logic   clk,
  input  logic   aclr,
  par2ser_if.slave s,
  output logic   sdata,
  output logic   sframe,
  output logic   bit_stb,
  output logic   busy,
  output state_t dbg_state
);

  localparam int CW = cnt_w(WIDTH);
  localparam int GW = gap_w(GAP);

  if (WIDTH < 2) begin : g_bad_width
    $error("par2ser_tx: WIDTH must be >= 2");
  end
  if (DIV < 1) begin : g_bad_div
    $error("par2ser_tx: DIV must be >= 1");
  end
  if (GAP < 0) begin : g_bad_gap
    $error("par2ser_tx: GAP must be >= 0");
  end

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic             msb_q;
  logic [CW-1:0]    bit_cnt;
  logic [GW-1:0]    gap_cnt;
  logic             accept;
  logic             tick;
  logic [WIDTH-1:0] rot;
  logic             rot_bit;

  assign accept    = s.s_valid && (state == S_IDLE);
  assign s.s_ready = (state == S_IDLE);
  assign dbg_state = state;

  // Rotating keeps every register bit in use; only the end facing the line is emitted.
  assign rot     = msb_q ? {shreg[WIDTH-2:0], shreg[WIDTH-1]} : {shreg[0], shreg[WIDTH-1:1]};
  assign rot_bit = msb_q ? rot[WIDTH-1] : rot[0];

  bit_tick_gen #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .aclr    (aclr),
    .restart (accept),
    .tick    (tick)
  );

`ifdef PAR2SER_PARITY_EN
  logic par_q;

  // Even parity of the word is captured with it at accept.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      par_q <= 1'b0;
    end else if (accept) begin
      par_q <= ^s.s_data;
    end
  end
`endif

  // Frame sequencer: IDLE accepts, SHIFT emits bits, GAP holds the line idle.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state   <= S_IDLE;
      shreg   <= '0;
      msb_q   <= 1'b0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      sdata   <= 1'b0;
      sframe  <= 1'b0;
      bit_stb <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          bit_stb <= 1'b0;
          if (s.s_valid) begin
            state   <= S_SHIFT;
            busy    <= 1'b1;
            shreg   <= s.s_data;
            msb_q   <= s.msb_first;
            bit_cnt <= CW'(WIDTH - 1 + PAR_BITS);
            sdata   <= s.msb_first ? s.s_data[WIDTH-1] : s.s_data[0];
            sframe  <= 1'b1;
            bit_stb <= 1'b1;
          end
        end
        S_SHIFT: begin
          bit_stb <= 1'b0;
          if (tick) begin
            if (bit_cnt == '0) begin
              sdata  <= 1'b0;
              sframe <= 1'b0;
              if (GAP > 0) begin
                state   <= S_GAP;
                gap_cnt <= GW'((GAP > 0) ? GAP - 1 : 0);
              end else begin
                state <= S_IDLE;
                busy  <= 1'b0;
              end
            end else begin
              bit_cnt <= bit_cnt - CW'(1);
              shreg   <= rot;
              bit_stb <= 1'b1;
`ifdef PAR2SER_PARITY_EN
              sdata   <= (bit_cnt == CW'(1)) ? par_q : rot_bit;
`else
              sdata   <= rot_bit;
`endif
            end
          end
        end
        S_GAP: begin
          bit_stb <= 1'b0;
          if (tick) begin
            if (gap_cnt == '0) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              gap_cnt <= gap_cnt - GW'(1);
            end
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_par2ser_tx.sv
// Directed bench for par2ser_tx: DUT a (WIDTH=8, DIV=4, GAP=1) and
// DUT b (WIDTH=8, DIV=1, GAP=0). Works with or without PAR2SER_PARITY_EN.
module tb_par2ser_tx;
  import par2ser_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic aclr;
  always #5 clk = ~clk;

  par2ser_if #(.WIDTH(8)) a_if ();
  par2ser_if #(.WIDTH(8)) b_if ();

  logic   a_sdata, a_sframe, a_bit_stb, a_busy;
  logic   b_sdata, b_sframe, b_bit_stb, b_busy;
  state_t a_state, b_state;

  par2ser_tx #(.WIDTH(8), .DIV(4), .GAP(1)) dut_a (
    .clk(clk), .aclr(aclr), .s(a_if),
    .sdata(a_sdata), .sframe(a_sframe), .bit_stb(a_bit_stb), .busy(a_busy),
    .dbg_state(a_state)
  );

  par2ser_tx #(.WIDTH(8), .DIV(1), .GAP(0)) dut_b (
    .clk(clk), .aclr(aclr), .s(b_if),
    .sdata(b_sdata), .sframe(b_sframe), .bit_stb(b_bit_stb), .busy(b_busy),
    .dbg_state(b_state)
  );

  // ---------------- scoreboard ----------------
  logic [0:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected serial stream, leftmost bit on the line first; parity bit appended when enabled.
  task automatic push_serial(input logic [7:0] v, input logic pbit);
    for (int i = 7; i >= 0; i--) exp_q.push_back(v[i]);
    if (PAR_BITS == 1) exp_q.push_back(pbit);
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input bit sel);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if ((sel ? b_if.s_ready : a_if.s_ready) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("ready_wait", {31'd0, ok}, 32'd1);
  endtask

  // Leaves the caller at the negedge of the first frame cycle (accept + 1).
  task automatic send(input bit sel, input logic [7:0] d, input logic msb);
    wait_ready(sel);
    if (sel) begin
      b_if.s_valid = 1'b1; b_if.s_data = d; b_if.msb_first = msb;
    end else begin
      a_if.s_valid = 1'b1; a_if.s_data = d; a_if.msb_first = msb;
    end
    @(negedge clk);
    if (sel) b_if.s_valid = 1'b0;
    else     a_if.s_valid = 1'b0;
  endtask

  // Walks one frame from its first cycle, checking bits against exp_q.
  task automatic collect(input string tag, input bit sel, input int div, input bit wiggle,
                         output int flen, output int nstb, output logic rdy_end);
    logic sd, sf, st, rd;
    logic cur = 1'b0;
    int hold_bad = 0;
    int space_bad = 0;
    bit done = 1'b0;
    flen = 0; nstb = 0; rdy_end = 1'b0;
    for (int k = 0; k < 400; k++) begin
      sd = sel ? b_sdata   : a_sdata;
      sf = sel ? b_sframe  : a_sframe;
      st = sel ? b_bit_stb : a_bit_stb;
      rd = sel ? b_if.s_ready : a_if.s_ready;
      if (k == 0) check({tag, "_first_stb"}, {30'd0, sf, st}, 32'd3);
      if (sf !== 1'b1) begin
        rdy_end = rd;
        done = 1'b1;
        break;
      end
      flen++;
      if (st === 1'b1) begin
        nstb++;
        if ((k % div) != 0) space_bad++;
        if (exp_q.size() == 0) begin
          check({tag, "_extra_bit"}, 32'd1, 32'd0);
        end else begin
          cur = exp_q.pop_front();
          check({tag, "_bit"}, {31'd0, sd}, {31'd0, cur});
        end
      end else if (sd !== cur) begin
        hold_bad++;
      end
      if (wiggle) begin
        a_if.s_data    = 8'($urandom_range(0, 255));
        a_if.msb_first = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    check({tag, "_frame_end"}, {31'd0, done}, 32'd1);
    check({tag, "_hold"}, hold_bad, 32'd0);
    check({tag, "_stb_spacing"}, space_bad, 32'd0);
    check({tag, "_bits_left"}, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  int   flen, nstb, na, rlow, gcyc, gbad, sf_cnt;
  int   acc[2];
  logic rdy_end;

  initial begin
    aclr = 1'b1;
    a_if.s_valid = 1'b0; a_if.s_data = 8'h00; a_if.msb_first = 1'b0;
    b_if.s_valid = 1'b0; b_if.s_data = 8'h00; b_if.msb_first = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values
    check("rst_sdata",   {31'd0, a_sdata},   32'd0);
    check("rst_sframe",  {31'd0, a_sframe},  32'd0);
    check("rst_bit_stb", {31'd0, a_bit_stb}, 32'd0);
    check("rst_busy",    {31'd0, a_busy},    32'd0);
    check("rst_ready",   {31'd0, a_if.s_ready}, 32'd1);
    check("rst_state",   32'(a_state), 32'(S_IDLE));
    check("rst_b_busy",  {31'd0, b_busy},    32'd0);
    check("rst_b_state", 32'(b_state), 32'(S_IDLE));
    aclr = 1'b0;
    @(negedge clk);

    // 1: A5 MSB first
    push_serial(8'b1010_0101, 1'b0);
    send(1'b0, 8'hA5, 1'b1);
    check("t1_state", 32'(a_state), 32'(S_SHIFT));
    check("t1_busy",  {31'd0, a_busy}, 32'd1);
    check("t1_ready", {31'd0, a_if.s_ready}, 32'd0);
    collect("t1", 1'b0, 4, 1'b0, flen, nstb, rdy_end);
    check("t1_sframe_len", flen, 32'(32 + 4 * PAR_BITS));
    check("t1_stb_count",  nstb, 32'(8 + PAR_BITS));

    // 2: 01 LSB first, inputs wiggled mid-frame
    push_serial(8'b1000_0000, 1'b1);
    send(1'b0, 8'h01, 1'b0);
    collect("t2", 1'b0, 4, 1'b1, flen, nstb, rdy_end);
    check("t2_sframe_len", flen, 32'(32 + 4 * PAR_BITS));

    // 3: back-to-back with s_valid held
    wait_ready(1'b0);
    a_if.s_valid = 1'b1; a_if.s_data = 8'hF0; a_if.msb_first = 1'b1;
    na = 0; rlow = 0; gcyc = 0; gbad = 0; acc[0] = 0; acc[1] = 0;
    for (int t = 0; t < 200; t++) begin
      if (a_if.s_ready === 1'b1 && a_if.s_valid === 1'b1) begin
        acc[na] = t;
        na++;
      end else if (na == 1) begin
        rlow++;
      end
      if (a_state == S_GAP) begin
        gcyc++;
        if (a_sdata !== 1'b0 || a_sframe !== 1'b0) gbad++;
      end
      if (na == 1 && t == acc[0] + 1) a_if.s_data = 8'h0F;
      if (na == 2) begin
        @(negedge clk);
        a_if.s_valid = 1'b0;
        break;
      end
      @(negedge clk);
    end
    check("t3_accepts",   na, 32'd2);
    check("t3_spacing",   acc[1] - acc[0], 32'(4 * (8 + PAR_BITS + 1) + 1));
    check("t3_ready_low", rlow, 32'(4 * (8 + PAR_BITS + 1)));
    check("t3_gap_len",   gcyc, 32'd4);
    check("t3_gap_idle",  gbad, 32'd0);
    if (na == 2) begin
      push_serial(8'b0000_1111, 1'b0);
      collect("t3b", 1'b0, 4, 1'b0, flen, nstb, rdy_end);
    end

    // 4: reset during data bit 3 of FF
    send(1'b0, 8'hFF, 1'b1);
    repeat (12) @(negedge clk);
    check("t4_mid_sframe", {31'd0, a_sframe}, 32'd1);
    aclr = 1'b1;
    #1;
    check("t4_rst_sdata",  {31'd0, a_sdata},  32'd0);
    check("t4_rst_sframe", {31'd0, a_sframe}, 32'd0);
    check("t4_rst_busy",   {31'd0, a_busy},   32'd0);
    check("t4_rst_ready",  {31'd0, a_if.s_ready}, 32'd1);
    @(negedge clk);
    aclr = 1'b0;
    sf_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (a_sframe !== 1'b0) sf_cnt++;
    end
    check("t4_no_resume", sf_cnt, 32'd0);
    push_serial(8'b1000_0001, 1'b0);
    send(1'b0, 8'h81, 1'b1);
    collect("t4b", 1'b0, 4, 1'b0, flen, nstb, rdy_end);
    check("t4_sframe_len", flen, 32'(32 + 4 * PAR_BITS));

    // 5: DIV=1, GAP=0
    push_serial(8'b1111_1111, 1'b0);
    send(1'b1, 8'hFF, 1'b1);
    collect("t5", 1'b1, 1, 1'b0, flen, nstb, rdy_end);
    check("t5_sframe_len", flen, 32'(8 + PAR_BITS));
    check("t5_stb_count",  nstb, 32'(8 + PAR_BITS));
    check("t5_ready_after", {31'd0, rdy_end}, 32'd1);

    // 6: 07 LSB first, parity 1 when enabled
    push_serial(8'b1110_0000, 1'b1);
    send(1'b0, 8'h07, 1'b0);
    collect("t6", 1'b0, 4, 1'b0, flen, nstb, rdy_end);
    check("t6_sframe_len", flen, 32'(32 + 4 * PAR_BITS));
    check("t6_stb_count",  nstb, 32'(8 + PAR_BITS));

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
